uart_rx_parity: RTL

UART receive path, the counterpart of the transmitter's parity generator. Synchronises the serial rx line, detects the start bit, and samples 8 data bits LSB-first at bit midpoints. Samples the optional parity bit and stop bit, then presents the byte with parity and framing status. Uses the same parity_type encoding as the transmit side, so a TX/RX pair configured identically interoperates.

---
 rtl/uart_rx_parity.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_parity.sv
// UART receiver: 2-FF synchroniser, start-bit glitch filter, 8N1 with optional odd/even parity.
// Defining UART_RX_BREAK_DET_EN builds break detection; otherwise break_det is tied low.
module uart_rx_parity #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic       break_det
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam logic [CntW-1:0] HalfLast = CntW'(Half - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } state_e;

  state_e          state;
  logic            rx_meta;
  logic            rx_s;
  logic [CntW-1:0] cnt;
  logic [2:0]      idx;
  logic [7:0]      shift;
  logic [1:0]      ptype;
  logic            par_err_q;
  logic            exp_par;
  logic            stop_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Odd parity expects the bit that makes the total count of ones odd.
  always_comb begin
    exp_par   = (ptype == 2'b01) ? ~^shift : ^shift;
    stop_fire = (state == StStop) && (cnt == BitLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= '0;
      idx        <= 3'd0;
      shift      <= 8'h00;
      ptype      <= 2'b00;
      par_err_q  <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        StIdle: begin
          if (!rx_s) begin
            state <= StStart;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        StStart: begin
          if (cnt == HalfLast) begin
            cnt <= '0;
            if (rx_s) begin
              state <= StIdle;
              busy  <= 1'b0;
            end else begin
              state     <= StData;
              ptype     <= parity_type;
              idx       <= 3'd0;
              par_err_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StData: begin
          if (cnt == BitLast) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (idx == 3'd7) begin
              state <= ((ptype == 2'b01) || (ptype == 2'b10)) ? StParity : StStop;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StParity: begin
          if (cnt == BitLast) begin
            cnt       <= '0;
            par_err_q <= (rx_s != exp_par);
            state     <= StStop;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StStop: begin
          if (cnt == BitLast) begin
            cnt        <= '0;
            data_out   <= shift;
            data_valid <= 1'b1;
            parity_err <= par_err_q;
            frame_err  <= ~rx_s;
            if (rx_s) begin
              state <= StIdle;
              busy  <= 1'b0;
            end else begin
              state <= StWaitHigh;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StWaitHigh: begin
          // A held-low line must return high before a new start bit is accepted.
          if (rx_s) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit   <= 1'b0;
      break_det <= 1'b0;
    end else begin
      break_det <= 1'b0;
      if (state == StStart) begin
        par_bit <= 1'b0;
      end else if ((state == StParity) && (cnt == BitLast)) begin
        par_bit <= rx_s;
      end
      if (stop_fire) begin
        break_det <= (shift == 8'h00) && !par_bit && !rx_s;
      end
    end
  end
`else
  assign break_det = 1'b0;
  logic unused_stop_fire;
  assign unused_stop_fire = stop_fire;
`endif

endmodule
